// File: rtl/phv_stage_buffer.sv
// Elastic buffer behind the stage action engine: one FIFO for PHVs and one for VLAN ids.
// Each FIFO presents its head through a registered first-word-fall-through output.

module phv_stage_fifo #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned AFULL_SLACK = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             drop
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AfullCnt = (AW+1)'(DEPTH - AFULL_SLACK);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d, mem_cnt;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             ready_q, ready_d;
  logic             push, pop, load;

  // count covers the output register too; rd_ptr tracks the oldest entry not yet presented
  always_comb begin
    pop      = out_valid_q & rd_ready;
    push     = wr_valid & ((count_q < FullCnt) | pop);
    drop     = wr_valid & ~push;
    mem_cnt  = count_q - (AW+1)'(out_valid_q);
    load     = (mem_cnt != '0) & (~out_valid_q | pop);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = load ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (AW+1)'(1);
    end
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[rd_ptr_q];
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
    ready_d = count_d < AfullCnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ready_q     <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign wr_ready = ready_q;
  assign rd_data  = out_data_q;
  assign rd_valid = out_valid_q;
endmodule

module phv_stage_buffer #(
  parameter int unsigned PHV_LEN        = 2304,
  parameter int unsigned C_VLANID_WIDTH = 12,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned AFULL_SLACK    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PHV_LEN-1:0]        phv_in,
  input  logic                      phv_valid_in,
  output logic                      ready_out,
  input  logic [C_VLANID_WIDTH-1:0] vlan_in,
  input  logic                      vlan_valid_in,
  output logic                      vlan_ready_out,
  output logic [PHV_LEN-1:0]        phv_out,
  output logic                      phv_valid_out,
  input  logic                      ready_in,
  output logic [C_VLANID_WIDTH-1:0] vlan_out,
  output logic                      vlan_valid_out,
  input  logic                      vlan_ready_in,
  output logic [15:0]               drop_cnt,
  output logic                      overflow
);
  logic [1:0]  rst_sync_q;
  logic        rst_int_n;
  logic        phv_drop, vlan_drop;
  logic [16:0] drop_sum;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        overflow_q, overflow_d;

  // Reset asserts asynchronously but releases two clocks later, synchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_int_n = rst_sync_q[1];

  phv_stage_fifo #(
    .WIDTH      (PHV_LEN),
    .DEPTH      (DEPTH),
    .AFULL_SLACK(AFULL_SLACK)
  ) u_phv_fifo (
    .clk     (clk),
    .rst_n   (rst_int_n),
    .wr_data (phv_in),
    .wr_valid(phv_valid_in),
    .wr_ready(ready_out),
    .rd_data (phv_out),
    .rd_valid(phv_valid_out),
    .rd_ready(ready_in),
    .drop    (phv_drop)
  );

  phv_stage_fifo #(
    .WIDTH      (C_VLANID_WIDTH),
    .DEPTH      (DEPTH),
    .AFULL_SLACK(AFULL_SLACK)
  ) u_vlan_fifo (
    .clk     (clk),
    .rst_n   (rst_int_n),
    .wr_data (vlan_in),
    .wr_valid(vlan_valid_in),
    .wr_ready(vlan_ready_out),
    .rd_data (vlan_out),
    .rd_valid(vlan_valid_out),
    .rd_ready(vlan_ready_in),
    .drop    (vlan_drop)
  );

  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + 17'(phv_drop) + 17'(vlan_drop);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    overflow_d = overflow_q | phv_drop | vlan_drop;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_phv_stage_buffer.sv
// Self-checking bench for phv_stage_buffer: scoreboard queues per FIFO plus per-scenario tasks.

module tb_phv_stage_buffer;
  localparam int unsigned PHV_LEN = 2304;
  localparam int unsigned VW      = 12;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned SLACK   = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [PHV_LEN-1:0] phv_in = '0;
  logic               phv_valid_in = 1'b0;
  logic               ready_out;
  logic [VW-1:0]      vlan_in = '0;
  logic               vlan_valid_in = 1'b0;
  logic               vlan_ready_out;
  logic [PHV_LEN-1:0] phv_out;
  logic               phv_valid_out;
  logic               ready_in = 1'b0;
  logic [VW-1:0]      vlan_out;
  logic               vlan_valid_out;
  logic               vlan_ready_in = 1'b0;
  logic [15:0]        drop_cnt;
  logic               overflow;

  always #5 clk = ~clk;

  phv_stage_buffer #(
    .PHV_LEN       (PHV_LEN),
    .C_VLANID_WIDTH(VW),
    .DEPTH         (DEPTH),
    .AFULL_SLACK   (SLACK)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .phv_in        (phv_in),
    .phv_valid_in  (phv_valid_in),
    .ready_out     (ready_out),
    .vlan_in       (vlan_in),
    .vlan_valid_in (vlan_valid_in),
    .vlan_ready_out(vlan_ready_out),
    .phv_out       (phv_out),
    .phv_valid_out (phv_valid_out),
    .ready_in      (ready_in),
    .vlan_out      (vlan_out),
    .vlan_valid_out(vlan_valid_out),
    .vlan_ready_in (vlan_ready_in),
    .drop_cnt      (drop_cnt),
    .overflow      (overflow)
  );

  logic [PHV_LEN-1:0] phv_q[$];
  logic [VW-1:0]      vlan_q[$];
  int                 pass_cnt = 0;
  int                 total_cnt = 0;
  int unsigned        exp_drop = 0;
  logic [PHV_LEN-1:0] prev_phv = '0;
  logic               prev_stall = 1'b0;

  function automatic logic [PHV_LEN-1:0] mk_phv(input logic [31:0] tag);
    logic [PHV_LEN-1:0] v;
    for (int i = 0; i < int'(PHV_LEN / 32); i++) v[i*32 +: 32] = tag ^ (i << 16);
    return v;
  endfunction

  // Scoreboard: every handshake seen on the output pops and compares the oldest expectation
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        total_cnt++;
        if (phv_valid_out !== 1'b1 || phv_out !== prev_phv) begin
          $display("FAIL phv_hold: valid=%b data=%h required valid=1 data=%h",
                   phv_valid_out, phv_out[31:0], prev_phv[31:0]);
        end else pass_cnt++;
      end
      prev_stall = phv_valid_out && !ready_in;
      prev_phv   = phv_out;
      if (phv_valid_out && ready_in) begin
        total_cnt++;
        if (phv_q.size() == 0) begin
          $display("FAIL phv_unexpected: got %h with nothing expected", phv_out[31:0]);
        end else begin
          logic [PHV_LEN-1:0] e;
          e = phv_q.pop_front();
          if (phv_out !== e) $display("FAIL phv_data: got %h required %h", phv_out[31:0], e[31:0]);
          else pass_cnt++;
        end
      end
      if (vlan_valid_out && vlan_ready_in) begin
        total_cnt++;
        if (vlan_q.size() == 0) begin
          $display("FAIL vlan_unexpected: got %h with nothing expected", vlan_out);
        end else begin
          logic [VW-1:0] e;
          e = vlan_q.pop_front();
          if (vlan_out !== e) $display("FAIL vlan_data: got %h required %h", vlan_out, e);
          else pass_cnt++;
        end
      end
    end
  end

  task automatic test_reset;
    total_cnt++;
    if (phv_valid_out !== 1'b0 || vlan_valid_out !== 1'b0 || phv_out !== '0 || vlan_out !== '0)
      $display("FAIL reset_outputs: pv=%b vv=%b pd=%h vd=%h required all 0",
               phv_valid_out, vlan_valid_out, phv_out[31:0], vlan_out);
    else pass_cnt++;
    total_cnt++;
    if (ready_out !== 1'b1 || vlan_ready_out !== 1'b1)
      $display("FAIL reset_ready: ready=%b vready=%b required 1 1", ready_out, vlan_ready_out);
    else pass_cnt++;
    total_cnt++;
    if (drop_cnt !== 16'd0 || overflow !== 1'b0)
      $display("FAIL reset_drop: drop=%0d ovf=%b required 0 0", drop_cnt, overflow);
    else pass_cnt++;
  endtask

  task automatic test_single;
    logic [PHV_LEN-1:0] a5;
    a5 = {(PHV_LEN / 8){8'hA5}};
    ready_in = 1'b1;
    phv_in = a5;
    phv_valid_in = 1'b1;
    phv_q.push_back(a5);
    @(posedge clk); #1;
    phv_valid_in = 1'b0;
    total_cnt++;
    if (phv_valid_out !== 1'b0) $display("FAIL single_latency: valid=%b required 0", phv_valid_out);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (phv_valid_out !== 1'b1 || phv_out !== a5 || ready_out !== 1'b1)
      $display("FAIL single_out: valid=%b data=%h ready=%b required 1 a5a5a5a5 1",
               phv_valid_out, phv_out[31:0], ready_out);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (phv_valid_out !== 1'b0) $display("FAIL single_pulse: valid=%b required 0", phv_valid_out);
    else pass_cnt++;
  endtask

  task automatic test_almost_full;
    ready_in = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      phv_in = mk_phv(32'(k));
      phv_valid_in = 1'b1;
      phv_q.push_back(phv_in);
      @(posedge clk); #1;
      total_cnt++;
      if (ready_out !== (k < 5)) $display("FAIL afull_ready_%0d: ready=%b required %b",
                                          k, ready_out, (k < 5));
      else pass_cnt++;
    end
    phv_valid_in = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (phv_valid_out !== 1'b1 || phv_out[31:0] !== 32'd1)
      $display("FAIL afull_head: valid=%b tag=%h required 1 1", phv_valid_out, phv_out[31:0]);
    else pass_cnt++;
    ready_in = 1'b1;
    for (int k = 2; k <= 6; k++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (k <= 5 && (phv_valid_out !== 1'b1 || phv_out[31:0] !== 32'(k)))
        $display("FAIL drain_no_bubble_%0d: valid=%b tag=%h required 1 %0d",
                 k, phv_valid_out, phv_out[31:0], k);
      else if (k == 6 && (phv_valid_out !== 1'b0 || ready_out !== 1'b1))
        $display("FAIL drain_empty: valid=%b ready=%b required 0 1", phv_valid_out, ready_out);
      else pass_cnt++;
    end
  endtask

  task automatic test_overflow;
    ready_in = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      phv_in = mk_phv(32'(k));
      phv_valid_in = 1'b1;
      if (k <= int'(DEPTH)) phv_q.push_back(phv_in);
      else exp_drop++;
      @(posedge clk); #1;
    end
    phv_valid_in = 1'b0;
    total_cnt++;
    if (drop_cnt !== 16'(exp_drop) || overflow !== 1'b1)
      $display("FAIL ovf_drop: drop=%0d ovf=%b required %0d 1", drop_cnt, overflow, exp_drop);
    else pass_cnt++;
    ready_in = 1'b1;
    for (int i = 0; i < 20 && (phv_valid_out || phv_q.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    total_cnt++;
    if (phv_q.size() != 0 || overflow !== 1'b1)
      $display("FAIL ovf_drain: left=%0d ovf=%b required 0 1", phv_q.size(), overflow);
    else pass_cnt++;
  endtask

  task automatic test_full_push_pop;
    ready_in = 1'b0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      phv_in = mk_phv(32'h41 + 32'(k));
      phv_valid_in = 1'b1;
      phv_q.push_back(phv_in);
      @(posedge clk); #1;
    end
    phv_valid_in = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (ready_out !== 1'b0 || phv_out[31:0] !== 32'h41)
      $display("FAIL full_state: ready=%b head=%h required 0 41", ready_out, phv_out[31:0]);
    else pass_cnt++;
    ready_in = 1'b1;
    phv_in = mk_phv(32'h49);
    phv_valid_in = 1'b1;
    phv_q.push_back(phv_in);
    @(posedge clk); #1;
    ready_in = 1'b0;
    total_cnt++;
    if (drop_cnt !== 16'(exp_drop)) $display("FAIL full_pushpop_drop: drop=%0d required %0d",
                                             drop_cnt, exp_drop);
    else pass_cnt++;
    // A further push with no pop must be dropped, proving the count stayed at DEPTH
    phv_in = mk_phv(32'h4A);
    exp_drop++;
    @(posedge clk); #1;
    phv_valid_in = 1'b0;
    total_cnt++;
    if (drop_cnt !== 16'(exp_drop)) $display("FAIL full_still_full: drop=%0d required %0d",
                                             drop_cnt, exp_drop);
    else pass_cnt++;
    ready_in = 1'b1;
    for (int i = 0; i < 20 && (phv_valid_out || phv_q.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    total_cnt++;
    if (phv_q.size() != 0) $display("FAIL full_drain: left=%0d required 0", phv_q.size());
    else pass_cnt++;
  endtask

  task automatic test_vlan_wrap;
    int sent = 0;
    int phv_seen = 0;
    vlan_ready_in = 1'b0;
    for (int cyc = 0; cyc < 300 && (sent < 20 || vlan_q.size() != 0); cyc++) begin
      vlan_ready_in = ~vlan_ready_in;
      if (sent < 20 && vlan_ready_out) begin
        vlan_in = VW'(sent + 1);
        vlan_valid_in = 1'b1;
        vlan_q.push_back(vlan_in);
        sent++;
      end else begin
        vlan_valid_in = 1'b0;
      end
      if (phv_valid_out) phv_seen++;
      @(posedge clk); #1;
    end
    vlan_valid_in = 1'b0;
    vlan_ready_in = 1'b0;
    total_cnt++;
    if (sent != 20 || vlan_q.size() != 0)
      $display("FAIL vlan_all: sent=%0d left=%0d required 20 0", sent, vlan_q.size());
    else pass_cnt++;
    total_cnt++;
    if (phv_seen != 0 || drop_cnt !== 16'(exp_drop))
      $display("FAIL vlan_isolation: phv_valid_cycles=%0d drop=%0d required 0 %0d",
               phv_seen, drop_cnt, exp_drop);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset;
    ready_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      phv_in = mk_phv(32'h60 + 32'(k));
      phv_valid_in = 1'b1;
      phv_q.push_back(phv_in);
      @(posedge clk); #1;
    end
    phv_valid_in = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    phv_q.delete();
    vlan_q.delete();
    exp_drop = 0;
    total_cnt++;
    if (phv_valid_out !== 1'b0 || drop_cnt !== 16'd0 || overflow !== 1'b0)
      $display("FAIL async_reset: valid=%b drop=%0d ovf=%b required 0 0 0",
               phv_valid_out, drop_cnt, overflow);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (ready_out !== 1'b1 || drop_cnt !== 16'd0 || overflow !== 1'b0)
      $display("FAIL post_reset: ready=%b drop=%0d ovf=%b required 1 0 0",
               ready_out, drop_cnt, overflow);
    else pass_cnt++;
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (phv_valid_out !== 1'b0) $display("FAIL stale_data_%0d: valid=%b tag=%h required 0",
                                           i, phv_valid_out, phv_out[31:0]);
      else pass_cnt++;
    end
    phv_in = mk_phv(32'h77);
    phv_valid_in = 1'b1;
    phv_q.push_back(phv_in);
    @(posedge clk); #1;
    phv_valid_in = 1'b0;
    for (int i = 0; i < 10 && phv_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    total_cnt++;
    if (phv_q.size() != 0) $display("FAIL post_reset_push: left=%0d required 0", phv_q.size());
    else pass_cnt++;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_single;
    test_almost_full;
    test_overflow;
    test_full_push_pop;
    test_vlan_wrap;
    test_mid_reset;
    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
